csa_pipe: RTL and testbench

Two-stage pipelined carry-select adder with valid/ready handshakes on both sides. It is the registered wrapper around the nibble adders and the 4-bit `muxb` select stage of the 8-bit carry-select adder. Stage 1 registers the low-half sum, the low-half carry and both high-half candidates. Stage 2 resolves the high half with the registered carry and presents the result. The block accepts one operation per cycle at full throughput, and back-pressure propagates without loss.

---
 rtl/csa_pipe.sv | 112 +++++++++++
 tb/tb_csa_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe.sv
// csa_pipe: two-stage pipelined carry-select adder with valid/ready handshakes.
// Stage 1 registers the low-half sum/carry and both high-half candidates;
// stage 2 picks the high half with the registered low carry.

// Half-width adder producing an (N+1)-bit result including carry out.
module csa_nib_add #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N:0]   s
);
    assign s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
endmodule

module csa_pipe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int H = W / 2;

    // Stage-1 state
    logic         s1_valid;
    logic [H-1:0] lo_sum;
    logic         c_lo;
    logic [H:0]   hi0;
    logic [H:0]   hi1;
    logic         sa;
    logic         sb;

    // Combinational adders feeding stage 1
    logic [H:0] lo_d;
    logic [H:0] hi0_d;
    logic [H:0] hi1_d;

    csa_nib_add #(.N(H)) u_lo  (.a(a[H-1:0]), .b(b[H-1:0]), .ci(cin),  .s(lo_d));
    csa_nib_add #(.N(H)) u_hi0 (.a(a[W-1:H]), .b(b[W-1:H]), .ci(1'b0), .s(hi0_d));
    csa_nib_add #(.N(H)) u_hi1 (.a(a[W-1:H]), .b(b[W-1:H]), .ci(1'b1), .s(hi1_d));

    // Handshake: stage 2 can take new data if empty or draining this cycle
    logic s2_free;
    logic s1_adv;
    logic in_xfer;

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign in_xfer  = in_valid && in_ready;

    // Carry-select mux: choose the high-half candidate by the registered low carry
    logic [H:0] hi_sel;
    always_comb begin
        hi_sel = c_lo ? hi1 : hi0;
    end

    // Stage 1: capture both high-half candidates and the low half on input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            lo_sum   <= '0;
            c_lo     <= 1'b0;
            hi0      <= '0;
            hi1      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                lo_sum   <= lo_d[H-1:0];
                c_lo     <= lo_d[H];
                hi0      <= hi0_d;
                hi1      <= hi1_d;
                sa       <= a[W-1];
                sb       <= b[W-1];
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: resolve the high half and present the result; holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (s1_adv) begin
                out_valid <= 1'b1;
                sum       <= {hi_sel[H-1:0], lo_sum};
                cout      <= hi_sel[H];
                ovf       <= (sa == sb) && (hi_sel[H-1] != sa);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_csa_pipe.sv
// tb_csa_pipe: directed and random checks of csa_pipe (W=8) against a queue scoreboard.
module tb_csa_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    csa_pipe #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_pop  = 0;
    logic [9:0]  sb_q[$];      // {ovf, cout, sum}
    logic        stall_prev = 1'b0;
    logic [9:0]  prev_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] s;
        logic       v;
        s = {1'b0, x} + {1'b0, y} + {8'd0, c};
        v = (x[7] == y[7]) && (s[7] != x[7]);
        return {v, s[8], s[7:0]};
    endfunction

    // One clock cycle: drive after the falling edge, sample 1 ns later, the
    // rising edge then performs whatever transfers were observed.
    task automatic step(input logic iv, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic ordy, output logic acc);
        logic [9:0] e;
        @(negedge clk);
        in_valid  = iv;
        a         = ta;
        b         = tb_v;
        cin       = tc;
        out_ready = ordy;
        #1;
        if (stall_prev)
            chk("stall_hold", {out_valid, ovf, cout, sum}, {1'b1, prev_res});
        stall_prev = out_valid && !out_ready;
        prev_res   = {ovf, cout, sum};
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("result", {ovf, cout, sum}, e);
                n_pop++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) sb_q.push_back(model(ta, tb_v, tc));
    endtask

    task automatic drain();
        logic acc;
        int   guard;
        guard = 0;
        while ((sb_q.size() != 0) && (guard < 50)) begin
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
            guard++;
        end
        chk("drain_done", sb_q.size(), 0);
    endtask

    initial begin
        logic       acc;
        int         k;
        int         pops0;
        int         done;
        int         cyc;
        logic [7:0] ra, rb;
        logic       rc;
        logic [7:0] ops[4];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", {ovf, cout, sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and nibble carry select
        step(1'b1, 8'h0F, 8'h01, 1'b0, 1'b1, acc);
        chk("lat_accept", acc, 1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        chk("lat_not_yet", out_valid, 0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        chk("lat_valid", out_valid, 1);
        chk("nib_0f_01", {ovf, cout, sum}, {2'b00, 8'h10});
        step(1'b1, 8'h0E, 8'h01, 1'b0, 1'b1, acc);
        step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, acc);
        step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, acc);
        step(1'b1, 8'h80, 8'h80, 1'b0, 1'b1, acc);
        step(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, acc);
        drain();

        // Back-pressure: out_ready low, offer 1+1..4+4
        ops = '{8'd1, 8'd2, 8'd3, 8'd4};
        k = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ops[k], ops[k], 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        chk("bp_accepted", k, 2);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_sum_hold", sum, 8'h02);
        pops0 = n_pop;
        step(1'b1, ops[k], ops[k], 1'b0, 1'b1, acc);
        chk("bp_restart_in_ready", in_ready, 1);
        if (acc) k++;
        step(1'b1, ops[k], ops[k], 1'b0, 1'b1, acc);
        if (acc) k++;
        chk("bp_all_accepted", k, 4);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        chk("bp_consecutive", n_pop - pops0, 4);
        drain();

        // Full throughput
        pops0 = n_pop;
        for (int i = 0; i < 256; i++) begin
            ra = 8'(i);
            step(1'b1, ra, 8'hFF - ra, ra[0], 1'b1, acc);
            if (!acc) chk("tp_accept", acc, 1);
        end
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        chk("tp_count", n_pop - pops0, 256);
        drain();

        // Reset mid-flight with two operations in flight
        step(1'b1, 8'h05, 8'h06, 1'b0, 1'b0, acc);
        step(1'b1, 8'h07, 8'h08, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
        chk("mr_full", {out_valid, in_ready}, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_sum", sum, 0);
        chk("mr_in_ready", in_ready, 1);
        sb_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pops0 = n_pop;
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        chk("mr_first_sum", sum, 8'h33);
        chk("mr_one_output", n_pop - pops0, 1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        chk("mr_no_stale", out_valid, 0);

        // Randomised traffic
        done = 0; cyc = 0;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        while ((done < 10000) && (cyc < 60000)) begin
            step(1'($urandom_range(0, 3) != 0), ra, rb, rc, 1'($urandom_range(0, 3) != 0), acc);
            if (acc) begin
                done++;
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            end
            cyc++;
        end
        chk("rand_count", done, 10000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
